// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared DRAM command/state types, widths and timing defaults for the bank command scheduler.
// Bank-side state encodings must stay aligned with the bank FSMs that drive ba_state.
`ifndef BANK_CMD_SCHEDULER_DEFINES
`define BANK_CMD_SCHEDULER_DEFINES
`define BA_BITS    2
`define ADDR_BITS  14
`define FSM_WIDTH1 2
`define FSM_WIDTH2 3
`endif

package usertype;

  localparam int BA_BITS    = `BA_BITS;
  localparam int ADDR_BITS  = `ADDR_BITS;
  localparam int FSM_WIDTH1 = `FSM_WIDTH1;
  localparam int FSM_WIDTH2 = `FSM_WIDTH2;

  // Wide enough for the largest timing parameter minus one
  localparam int CNT_W = 5;

  localparam int DEF_T_INIT = 8;
  localparam int DEF_T_RCD  = 3;
  localparam int DEF_T_RP   = 3;
  localparam int DEF_T_RAS  = 6;
  localparam int DEF_T_WR   = 4;
  localparam int DEF_T_CCD  = 2;
  localparam int DEF_T_RRD  = 2;
  localparam int DEF_T_RFC  = 10;

  typedef enum logic [FSM_WIDTH2-1:0] {
    B_IDLE,
    B_ACTIVE,
    B_ROW_OPEN,
    B_READ,
    B_WRITE,
    B_PRE,
    B_REFRESHING,
    B_ISSUE_REFRESH
  } bank_state_t;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    RD,
    WR,
    PRE,
    REF
  } dram_cmd_t;

  typedef enum logic [FSM_WIDTH1-1:0] {
    FSM_INIT,
    FSM_IDLE,
    FSM_REFRESH
  } ctrl_state_t;

  typedef enum logic {
    S_INIT,
    S_RUN
  } sched_state_t;

  function automatic dram_cmd_t state_to_cmd(input bank_state_t s);
    case (s)
      B_ACTIVE:        return ACT;
      B_READ:          return RD;
      B_WRITE:         return WR;
      B_PRE:           return PRE;
      B_ISSUE_REFRESH: return REF;
      default:         return NOP;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// Bank-FSM side of the scheduler: per-bank requests in, stalls/controller state and the DRAM command bus out.
interface bank_cmd_scheduler_if
  import usertype::*;
#(
  parameter int NB = 4
);

  bank_state_t            ba_state [NB];
  logic [NB-1:0]          ba_issue;
  logic [ADDR_BITS-1:0]   ba_addr  [NB];
  logic [NB-1:0]          stall;
  ctrl_state_t            state_o  [NB];
  logic                   cmd_valid_o;
  dram_cmd_t              cmd_o;
  logic [BA_BITS-1:0]     cmd_bank_o;
  logic [ADDR_BITS-1:0]   cmd_addr_o;

  modport master (
    output ba_state, ba_issue, ba_addr,
    input  stall, state_o, cmd_valid_o, cmd_o, cmd_bank_o, cmd_addr_o
  );

  modport slave (
    input  ba_state, ba_issue, ba_addr,
    output stall, state_o, cmd_valid_o, cmd_o, cmd_bank_o, cmd_addr_o
  );

endinterface

// File: rtl/bank_cmd_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: the first requester at or after ptr (wrapping) wins, purely combinational.
module rr_arbiter
  import usertype::*;
#(
  parameter int NB = 4
) (
  input  logic [NB-1:0]      req,
  input  logic [BA_BITS-1:0] ptr,
  output logic [NB-1:0]      gnt
);

  logic [NB-1:0] req_rot;
  logic [NB-1:0] gnt_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    req_rot = NB'({req, req} >> ptr);
    gnt_rot = req_rot & (~req_rot + NB'(1));
    gnt     = NB'(({gnt_rot, gnt_rot} << ptr) >> NB);
  end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Arbitrates per-bank DRAM command requests under JEDEC-style timing; one registered command per cycle.
// NB must not exceed 2**BA_BITS.
module bank_cmd_scheduler
  import usertype::*;
#(
  parameter int NB     = 4,
  parameter int T_INIT = DEF_T_INIT,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RAS  = DEF_T_RAS,
  parameter int T_WR   = DEF_T_WR,
  parameter int T_CCD  = DEF_T_CCD,
  parameter int T_RRD  = DEF_T_RRD,
  parameter int T_RFC  = DEF_T_RFC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bank_cmd_scheduler_if.slave  bus
);

  sched_state_t           state_q;
  sched_state_t           state_d;
  logic [CNT_W-1:0]       init_cnt;
  logic                   init_busy;

  dram_cmd_t              req_cmd [NB];
  logic [NB-1:0]          has_cmd;
  logic [NB-1:0]          eligible;
  logic [NB-1:0]          gnt;
  logic                   gnt_any;
  logic [BA_BITS-1:0]     gnt_idx;
  dram_cmd_t              gnt_cmd;
  logic [ADDR_BITS-1:0]   gnt_addr;
  logic [BA_BITS-1:0]     rr_ptr;
  logic [NB-1:0]          ref_pulse;

  logic [CNT_W-1:0]       rcd_cnt [NB];
  logic [CNT_W-1:0]       ras_cnt [NB];
  logic [CNT_W-1:0]       wr_cnt  [NB];
  logic [CNT_W-1:0]       rp_cnt  [NB];
  logic [CNT_W-1:0]       rfc_cnt [NB];
  logic [CNT_W-1:0]       rrd_cnt;
  logic [CNT_W-1:0]       ccd_cnt;

  assign init_busy = (state_q == S_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_cnt == '0) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= CNT_W'(T_INIT - 1);
    end else if (init_busy) begin
      init_cnt <= sat_dec(init_cnt);
    end
  end

  // A request is eligible only once every counter guarding its command has drained
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      req_cmd[i]  = state_to_cmd(bus.ba_state[i]);
      has_cmd[i]  = (req_cmd[i] != NOP);
      eligible[i] = 1'b0;
      if (bus.ba_issue[i] && !init_busy) begin
        case (req_cmd[i])
          ACT:     eligible[i] = (rp_cnt[i] == '0) && (rfc_cnt[i] == '0) && (rrd_cnt == '0);
          RD, WR:  eligible[i] = (rcd_cnt[i] == '0) && (ccd_cnt == '0);
          PRE:     eligible[i] = (ras_cnt[i] == '0) && (wr_cnt[i] == '0);
          REF:     eligible[i] = 1'b1;
          default: eligible[i] = 1'b0;
        endcase
      end
    end
  end

  rr_arbiter #(
    .NB (NB)
  ) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_any  = |gnt;
    gnt_idx  = '0;
    gnt_cmd  = NOP;
    gnt_addr = '0;
    for (int i = 0; i < NB; i++) begin
      if (gnt[i]) begin
        gnt_idx  = BA_BITS'(i);
        gnt_cmd  = req_cmd[i];
        gnt_addr = bus.ba_addr[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bus.stall[i] = init_busy ? bus.ba_issue[i]
                               : (bus.ba_issue[i] && has_cmd[i] && !gnt[i]);
      if (init_busy) begin
        bus.state_o[i] = FSM_INIT;
      end else if (ref_pulse[i]) begin
        bus.state_o[i] = FSM_REFRESH;
      end else begin
        bus.state_o[i] = FSM_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        rcd_cnt[i] <= '0;
        ras_cnt[i] <= '0;
        wr_cnt[i]  <= '0;
        rp_cnt[i]  <= '0;
        rfc_cnt[i] <= '0;
      end
      rrd_cnt <= '0;
      ccd_cnt <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        rcd_cnt[i] <= (gnt[i] && gnt_cmd == ACT) ? CNT_W'(T_RCD - 1) : sat_dec(rcd_cnt[i]);
        ras_cnt[i] <= (gnt[i] && gnt_cmd == ACT) ? CNT_W'(T_RAS - 1) : sat_dec(ras_cnt[i]);
        wr_cnt[i]  <= (gnt[i] && gnt_cmd == WR)  ? CNT_W'(T_WR - 1)  : sat_dec(wr_cnt[i]);
        rp_cnt[i]  <= (gnt[i] && gnt_cmd == PRE) ? CNT_W'(T_RP - 1)  : sat_dec(rp_cnt[i]);
        rfc_cnt[i] <= (gnt[i] && gnt_cmd == REF) ? CNT_W'(T_RFC - 1) : sat_dec(rfc_cnt[i]);
      end
      rrd_cnt <= (gnt_any && gnt_cmd == ACT) ? CNT_W'(T_RRD - 1) : sat_dec(rrd_cnt);
      ccd_cnt <= (gnt_any && (gnt_cmd == RD || gnt_cmd == WR)) ? CNT_W'(T_CCD - 1)
                                                               : sat_dec(ccd_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == BA_BITS'(NB - 1)) ? '0 : gnt_idx + BA_BITS'(1);
    end
  end

  // Bank and address hold their last value on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_valid_o <= 1'b0;
      bus.cmd_o       <= NOP;
      bus.cmd_bank_o  <= '0;
      bus.cmd_addr_o  <= '0;
      ref_pulse       <= '0;
    end else begin
      bus.cmd_valid_o <= gnt_any;
      bus.cmd_o       <= gnt_any ? gnt_cmd : NOP;
      if (gnt_any) begin
        bus.cmd_bank_o <= gnt_idx;
        bus.cmd_addr_o <= (gnt_cmd == REF) ? '0 : gnt_addr;
      end
      for (int i = 0; i < NB; i++) begin
        ref_pulse[i] <= gnt[i] && (gnt_cmd == REF);
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Randomized bench: a time-stamp reference model predicts stalls, commands and controller state; a monitor scores them.
module tb_bank_cmd_scheduler;
  import usertype::*;

  localparam int NB    = 4;
  localparam int TI    = 8;
  localparam int TRCD  = 3;
  localparam int TRP   = 3;
  localparam int TRAS  = 6;
  localparam int TWR   = 4;
  localparam int TCCD  = 2;
  localparam int TRRD  = 2;
  localparam int TRFC  = 10;
  localparam int NEVER = -1000;

  typedef struct {
    logic                        vld;
    dram_cmd_t                   cmd;
    logic [BA_BITS-1:0]          bank;
    logic [ADDR_BITS-1:0]        addr;
    logic [NB*FSM_WIDTH1-1:0]    st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_cmd_scheduler_if #(.NB(NB)) bus ();

  bank_cmd_scheduler #(
    .NB(NB), .T_INIT(TI), .T_RCD(TRCD), .T_RP(TRP), .T_RAS(TRAS),
    .T_WR(TWR), .T_CCD(TCCD), .T_RRD(TRRD), .T_RFC(TRFC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  exp_t q[$];

  // Reference model: cycle count since reset release and the cycle of each last command
  int now;
  int ptr;
  int last_act [NB];
  int last_pre [NB];
  int last_ref [NB];
  int last_wr  [NB];
  int last_act_any;
  int last_col_any;
  logic [BA_BITS-1:0]   e_bank;
  logic [ADDR_BITS-1:0] e_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic dram_cmd_t cmd_of(input bank_state_t s);
    case (s)
      B_ACTIVE:        return ACT;
      B_READ:          return RD;
      B_WRITE:         return WR;
      B_PRE:           return PRE;
      B_ISSUE_REFRESH: return REF;
      default:         return NOP;
    endcase
  endfunction

  function automatic bit may_issue(input int b, input dram_cmd_t c);
    case (c)
      ACT:     return (now - last_pre[b] >= TRP) && (now - last_ref[b] >= TRFC)
                      && (now - last_act_any >= TRRD);
      RD, WR:  return (now - last_act[b] >= TRCD) && (now - last_col_any >= TCCD);
      PRE:     return (now - last_act[b] >= TRAS) && (now - last_wr[b] >= TWR);
      REF:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB*FSM_WIDTH1-1:0] dut_state();
    logic [NB*FSM_WIDTH1-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i*FSM_WIDTH1 +: FSM_WIDTH1] = bus.state_o[i];
    return v;
  endfunction

  task automatic model_reset();
    now = 0;
    ptr = 0;
    for (int b = 0; b < NB; b++) begin
      last_act[b] = NEVER;
      last_pre[b] = NEVER;
      last_ref[b] = NEVER;
      last_wr[b]  = NEVER;
    end
    last_act_any = NEVER;
    last_col_any = NEVER;
    e_bank = '0;
    e_addr = '0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(bus.cmd_valid_o), 64'(0));
    chk({tag, "_cmd"},   64'(bus.cmd_o),       64'(NOP));
    chk({tag, "_bank"},  64'(bus.cmd_bank_o),  64'(0));
    chk({tag, "_addr"},  64'(bus.cmd_addr_o),  64'(0));
    chk({tag, "_state"}, 64'(dut_state()),     64'(0));
  endtask

  // Drive one cycle of requests, check stall immediately, queue the next-cycle outputs
  task automatic drive_cycle(input int mode);
    int unsigned r;
    int g;
    dram_cmd_t gc;
    logic [NB-1:0] es;
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      if (mode == 1) begin
        bus.ba_issue[b] = 1'b1;
        r = $urandom_range(0, 9);
        if (r < 4)      bus.ba_state[b] = B_ACTIVE;
        else if (r < 6) bus.ba_state[b] = B_READ;
        else if (r < 8) bus.ba_state[b] = B_WRITE;
        else if (r < 9) bus.ba_state[b] = B_PRE;
        else            bus.ba_state[b] = B_ISSUE_REFRESH;
      end else begin
        bus.ba_issue[b] = ($urandom_range(0, 99) < 65);
        r = $urandom_range(0, 7);
        bus.ba_state[b] = bank_state_t'(3'(r));
      end
      bus.ba_addr[b] = ADDR_BITS'($urandom);
    end
    #1;
    g  = -1;
    gc = NOP;
    if (now >= TI) begin
      for (int k = 0; k < NB; k++) begin
        int b;
        dram_cmd_t c;
        b = (ptr + k) % NB;
        c = cmd_of(bus.ba_state[b]);
        if (g < 0 && bus.ba_issue[b] && c != NOP && may_issue(b, c)) begin
          g  = b;
          gc = c;
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      es[b] = (now < TI) ? bus.ba_issue[b]
                         : (bus.ba_issue[b] && cmd_of(bus.ba_state[b]) != NOP && b != g);
    end
    chk("stall", 64'(bus.stall), 64'(es));
    if (g >= 0) begin
      e_bank = BA_BITS'(g);
      e_addr = (gc == REF) ? '0 : bus.ba_addr[g];
      case (gc)
        ACT: begin last_act[g] = now; last_act_any = now; end
        RD:  last_col_any = now;
        WR:  begin last_col_any = now; last_wr[g] = now; end
        PRE: last_pre[g] = now;
        REF: last_ref[g] = now;
        default: ;
      endcase
      ptr = (g + 1) % NB;
    end
    e.vld  = (g >= 0);
    e.cmd  = gc;
    e.bank = e_bank;
    e.addr = e_addr;
    e.st   = '0;
    for (int b = 0; b < NB; b++) begin
      ctrl_state_t s;
      if (now + 1 < TI)             s = FSM_INIT;
      else if (g == b && gc == REF) s = FSM_REFRESH;
      else                          s = FSM_IDLE;
      e.st[b*FSM_WIDTH1 +: FSM_WIDTH1] = s;
    end
    q.push_back(e);
    now++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cmd_valid", 64'(bus.cmd_valid_o), 64'(e.vld));
        chk("cmd",       64'(bus.cmd_o),       64'(e.cmd));
        chk("cmd_bank",  64'(bus.cmd_bank_o),  64'(e.bank));
        chk("cmd_addr",  64'(bus.cmd_addr_o),  64'(e.addr));
        chk("state_o",   64'(dut_state()),     64'(e.st));
      end
    end
  end

  initial begin : driver
    int seg_len  [4] = '{400, 300, 300, 200};
    int seg_mode [4] = '{0, 1, 0, 1};
    bus.ba_issue = '0;
    for (int b = 0; b < NB; b++) begin
      bus.ba_state[b] = B_IDLE;
      bus.ba_addr[b]  = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_reset_outs("release");
      drive_cycle(seg_mode[s]);
      for (int c = 1; c < seg_len[s]; c++) begin
        @(negedge clk);
        drive_cycle(seg_mode[s]);
      end
      if (s < 3) begin
        // Reset lands while every bank is asking for a command; the pending grant must vanish
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
          bus.ba_issue[b] = 1'b1;
          bus.ba_state[b] = (b == 3) ? B_ISSUE_REFRESH : B_ACTIVE;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        chk("mid_rst_stall", 64'(bus.stall), 64'({NB{1'b1}}));
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
